// File: rtl/ram8_bank.sv
// ram8_bank: 8-word register bank with one-hot write decode, 8-way read mux,
// per-word valid bits and a count of distinct words written since reset.
// Optional build macro RAM8_BYPASS_EN: when defined, a write in progress is
// forwarded combinationally to out/out_valid before the clock edge.
module ram8_bank #(
   parameter int unsigned WIDTH = 16,
   parameter int unsigned DEPTH = 8
) (
   input  logic             clk,
   input  logic             reset,
   input  logic [WIDTH-1:0] in,
   input  logic             load,
   input  logic [2:0]       address,
   output logic [WIDTH-1:0] out,
   output logic             out_valid,
   output logic [3:0]       wr_count
);

   logic [WIDTH-1:0] mem_q [DEPTH];
   logic [WIDTH-1:0] mem_d [DEPTH];
   logic [DEPTH-1:0] valid_q;
   logic [DEPTH-1:0] valid_d;
   logic [3:0]       wr_count_q;
   logic [3:0]       wr_count_d;
   logic [DEPTH-1:0] word_en;

   // One-hot write enable per word; all zero when load is low
   always_comb begin
      word_en = '0;
      for (int unsigned i = 0; i < DEPTH; i++) begin
         word_en[i] = load && (address == 3'(i));
      end
   end

   // Next-state: enabled word takes in, its valid bit sets, count bumps on first write
   always_comb begin
      mem_d      = mem_q;
      valid_d    = valid_q;
      wr_count_d = wr_count_q;
      for (int unsigned i = 0; i < DEPTH; i++) begin
         if (word_en[i]) begin
            mem_d[i]   = in;
            valid_d[i] = 1'b1;
            if (!valid_q[i]) begin
               wr_count_d = wr_count_q + 4'd1;
            end
         end
      end
   end

   // State registers; synchronous reset overrides any write in the same cycle
   always_ff @(posedge clk) begin
      if (reset) begin
         for (int unsigned i = 0; i < DEPTH; i++) begin
            mem_q[i] <= '0;
         end
         valid_q    <= '0;
         wr_count_q <= '0;
      end else begin
         for (int unsigned i = 0; i < DEPTH; i++) begin
            mem_q[i] <= mem_d[i];
         end
         valid_q    <= valid_d;
         wr_count_q <= wr_count_d;
      end
   end

   // Combinational read mux, with optional write-through forwarding
   always_comb begin
      out       = mem_q[address];
      out_valid = valid_q[address];
`ifdef RAM8_BYPASS_EN
      if (load && !reset) begin
         out       = in;
         out_valid = 1'b1;
      end
`else
`endif
   end

   assign wr_count = wr_count_q;

endmodule

// File: tb/tb_ram8_bank.sv
// tb_ram8_bank: directed self-checking bench for ram8_bank.
module tb_ram8_bank;

   logic        clk;
   logic        reset;
   logic [15:0] in;
   logic        load;
   logic [2:0]  address;
   logic [15:0] out;
   logic        out_valid;
   logic [3:0]  wr_count;

   int unsigned errors;
   int unsigned checks;
   logic [15:0] model [8];

   ram8_bank #(.WIDTH(16), .DEPTH(8)) dut (
      .clk       (clk),
      .reset     (reset),
      .in        (in),
      .load      (load),
      .address   (address),
      .out       (out),
      .out_valid (out_valid),
      .wr_count  (wr_count)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // Present one write, let the edge take it, then drop load
   task automatic wr(input logic [2:0] a, input logic [15:0] d);
      address = a;
      in      = d;
      load    = 1'b1;
      @(posedge clk);
      #1;
      load = 1'b0;
   endtask

   task automatic do_reset();
      reset = 1'b1;
      load  = 1'b0;
      @(posedge clk);
      #1;
      reset = 1'b0;
   endtask

   initial begin
      errors  = 0;
      checks  = 0;
      reset   = 1'b0;
      load    = 1'b0;
      in      = '0;
      address = '0;
      @(posedge clk);
      #1;
      do_reset();

      // 1: post-reset sweep
      for (int a = 0; a < 8; a++) begin
         address = 3'(a);
         #1;
         chk($sformatf("rst_out[%0d]", a), 32'(out), 32'h0);
         chk($sformatf("rst_valid[%0d]", a), 32'(out_valid), 32'h0);
      end
      chk("rst_count", 32'(wr_count), 32'h0);

      // 2: fill 0x1111*k, count steps 1..8
      for (int k = 0; k < 8; k++) begin
         wr(3'(k), 16'(32'h1111 * k));
         chk($sformatf("fill_count[%0d]", k), 32'(wr_count), 32'(k + 1));
      end
      for (int k = 0; k < 8; k++) begin
         address = 3'(k);
         #1;
         chk($sformatf("fill_out[%0d]", k), 32'(out), 32'h1111 * k);
         chk($sformatf("fill_valid[%0d]", k), 32'(out_valid), 32'h1);
      end
      chk("fill_count_end", 32'(wr_count), 32'h8);

      // 3: back-to-back rewrite of addr 3 from a clean state
      do_reset();
      wr(3'd3, 16'hABCD);
      chk("rw_count1", 32'(wr_count), 32'h1);
      wr(3'd3, 16'h1234);
      chk("rw_count2", 32'(wr_count), 32'h1);
      address = 3'd3; #1;
      chk("rw_out3", 32'(out), 32'h1234);
      chk("rw_valid3", 32'(out_valid), 32'h1);
      address = 3'd2; #1;
      chk("rw_out2", 32'(out), 32'h0);
      chk("rw_valid2", 32'(out_valid), 32'h0);
      address = 3'd4; #1;
      chk("rw_out4", 32'(out), 32'h0);
      chk("rw_valid4", 32'(out_valid), 32'h0);

      // 4: reset wins over a simultaneous write
      reset   = 1'b1;
      load    = 1'b1;
      in      = 16'hFFFF;
      address = 3'd5;
      @(posedge clk);
      #1;
      reset = 1'b0;
      load  = 1'b0;
      #1;
      chk("rstld_out5", 32'(out), 32'h0);
      chk("rstld_valid5", 32'(out_valid), 32'h0);
      chk("rstld_count", 32'(wr_count), 32'h0);
      address = 3'd3; #1;
      chk("rstld_out3", 32'(out), 32'h0);

      // 5: visibility during a write cycle, before and after the edge
      wr(3'd6, 16'h00AA);
      address = 3'd6;
      in      = 16'h5555;
      load    = 1'b1;
      #1;
`ifdef RAM8_BYPASS_EN
      chk("wcyc_out_pre", 32'(out), 32'h5555);
`else
      chk("wcyc_out_pre", 32'(out), 32'h00AA);
`endif
      chk("wcyc_valid_pre", 32'(out_valid), 32'h1);
      @(posedge clk);
      #1;
      load = 1'b0;
      #1;
      chk("wcyc_out_post", 32'(out), 32'h5555);
      chk("wcyc_count", 32'(wr_count), 32'h1);

      // 6: full write, then 20 idle cycles with random in/address
      do_reset();
      for (int k = 0; k < 8; k++) begin
         model[k] = 16'((k * 32'h0101) ^ 32'h5A00);
         wr(3'(k), model[k]);
      end
      chk("full_count", 32'(wr_count), 32'h8);
      for (int c = 0; c < 20; c++) begin
         in      = 16'($urandom);
         address = 3'($urandom_range(0, 7));
         @(posedge clk);
         #1;
         chk($sformatf("idle_out[c%0d,a%0d]", c, address), 32'(out), 32'(model[address]));
      end
      for (int k = 0; k < 8; k++) begin
         address = 3'(k);
         #1;
         chk($sformatf("hold_out[%0d]", k), 32'(out), 32'(model[k]));
         chk($sformatf("hold_valid[%0d]", k), 32'(out_valid), 32'h1);
      end
      chk("hold_count", 32'(wr_count), 32'h8);

      // Rewrite of a valid word at full occupancy keeps the count at 8
      wr(3'd7, 16'hBEEF);
      model[7] = 16'hBEEF;
      address = 3'd7; #1;
      chk("sat_out7", 32'(out), 32'(model[7]));
      chk("sat_count", 32'(wr_count), 32'h8);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/ram8_bank.md
Name: ram8_bank

Overview:
- 8-word register bank: the Project 3 RAM8 stage that sits directly downstream of the 4/8-way demultiplexers.
- Internally, `load` is routed one-hot to exactly one word register by `address`, the demux role.
- The addressed word is returned on `out` through an 8-way mux.
- Sequential storage element that the RAM64 / memory hierarchy is built from.

Parameters:
- WIDTH, 16, data bits per word.
- DEPTH, 8, word count; fixed at 8 in this block; addresses are 3 bits.

Ports:
- clk  input  1  system clock; all state updates on rising edge.
- reset  input  1  synchronous, active-high reset; sampled on rising edge of clk.
- in  input  WIDTH  write data.
- load  input  1  write enable for the word selected by address.
- address  input  3  word select for both write and read.
- out  output  WIDTH  contents of word[address].
- out_valid  output  1  1 when word[address] has been written since the last reset.
- wr_count  output  4  number of distinct words written since reset, 0..8.

Behaviour:
- One clock; reset is synchronous and active-high. Rising edge of clk with reset=1:
  - all 8 words <= 0;
  - valid[7:0] <= 0;
  - wr_count <= 0;
  - load is ignored that cycle.
- After reset, out=0, out_valid=0, wr_count=0 for every address.
- Write, on a rising edge with reset=0 and load=1:
  - word[address] <= in;
  - valid[address] <= 1;
  - all other words are unchanged.
- Load decode is one-hot: at most one word register enable is active per cycle; load=0 means no enables.
- Read is combinational: out = word[address] and out_valid = valid[address], both updating in the same cycle address changes.
- Write latency: a written value appears on out in the cycle after the edge, if address is held. Exception: see Optional Feature.
- wr_count:
  - increments by 1 on a write to a word whose valid bit was 0;
  - does not increment on a rewrite of a valid word;
  - saturates naturally at 8, since only 8 valid bits exist.
  - wr_count equals popcount(valid) at all times; the implementation may use either a counter or a popcount, but the result must match.
- Rewrite of the same address on consecutive cycles: the last value wins; wr_count changes only on the first write.
- load=1 with X-free address is the only write path. Address changes while load=0 have no effect on state.
- Reset mid-sequence, with reset=1 and load=1 in the same cycle: reset wins; the word is not written and valid stays 0.
- No wrap-around: address is exactly 3 bits, so all 8 values are legal.

Optional Feature:
- Macro: RAM8_BYPASS_EN
- Defined: write-through forwarding.
  - While load=1 and reset=0, out = in and out_valid = 1 combinationally in the same cycle, before the edge.
  - The stored value is still updated at the edge as normal.
  - wr_count is not affected by the bypass.
- Undefined:
  - out always reflects stored contents;
  - during a write cycle, out shows the old word[address] until the edge.

Test Plan:
1. Reset, then sweep address 0..7 with load=0 -> out=0x0000, out_valid=0 for all; wr_count=0.
2. Write 0x1111*k to address k for k=0..7, one per cycle, then read back all -> out=0x0000,0x1111,...,0x7777; out_valid=1; wr_count steps 1..8 and ends at 8.
3. Write 0xABCD to addr 3, then 0x1234 to addr 3 -> read addr 3 gives 0x1234; addr 2 and addr 4 unchanged; wr_count increments only on the first write.
4. Assert reset=1 together with load=1, in=0xFFFF, addr=5 -> next cycle out=0x0000 at addr 5, out_valid=0, wr_count=0.
5. Write-cycle visibility, with addr 6 holding 0x00AA, in=0x5555, load=1, sampled before the edge:
   - RAM8_BYPASS_EN undefined -> out=0x00AA;
   - RAM8_BYPASS_EN defined -> out=0x5555.
   - In both builds, after the edge out=0x5555.
6. Hold load=0 for 20 cycles while in and address toggle randomly after a full write -> all 8 stored words and wr_count=8 are unchanged.
